// File: rtl/jtd_sensor_front.sv
// Sensor front end: sync + debounce of two loop detectors and an emergency key,
// request latches with ack, emergency FSM. Macro JTD_VEH_CNT_EN builds vehicle counters.

module jtd_db_chan #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt,
  output logic rise
);
  localparam int DW = $clog2(DB_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic [DW-1:0] dbc;
  logic          filt_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync      <= '0;
      dbc       <= '0;
      filt      <= 1'b0;
      filt_prev <= 1'b0;
    end else begin
      sync      <= {sync[0], raw};
      filt_prev <= filt;
      if (sync[1] != filt) begin
        if (dbc == DB_LAST) begin
          filt <= ~filt;
          dbc  <= '0;
        end else begin
          dbc  <= dbc + DW'(1);
        end
      end else begin
        dbc <= '0;
      end
    end
  end

  assign rise = filt & ~filt_prev;
endmodule

module jtd_sensor_front #(
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det1_raw,
  input  logic             det2_raw,
  input  logic             emg_raw,
  input  logic             ack1,
  input  logic             ack2,
  output logic             sen1,
  output logic             sen2,
  output logic             ys,
  output logic [CNT_W-1:0] veh_cnt1,
  output logic [CNT_W-1:0] veh_cnt2
);
  localparam int NUM_CH = 3;
  localparam int NUM_RD = 2;
  localparam int HW     = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, ACTIVE} emg_state_t;

  // channel 0/1 are roads, channel 2 is the emergency key
  logic [NUM_CH-1:0] raw_vec, filt, rise;
  logic [NUM_RD-1:0] ack, req, req_nxt;
  emg_state_t        state, state_nxt;
  logic [HW-1:0]     hold, hold_nxt;
  logic              emg_nxt;
  logic              unused_filt;

  assign raw_vec     = {emg_raw, det2_raw, det1_raw};
  assign ack         = {ack2, ack1};
  assign unused_filt = &{1'b0, filt[NUM_RD-1:0]};

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      jtd_db_chan #(.DB_CYCLES(DB_CYCLES)) u_chan (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_vec[g]),
        .filt (filt[g]),
        .rise (rise[g])
      );
    end
  endgenerate

  // set beats ack on collision
  always_comb begin
    for (int i = 0; i < NUM_RD; i++)
      req_nxt[i] = rise[i] | (req[i] & ~ack[i]);
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    case (state)
      IDLE: begin
        if (rise[2]) begin
          state_nxt = ACTIVE;
          hold_nxt  = HOLD_LAST;
        end
      end
      ACTIVE: begin
        if (rise[2])
          hold_nxt = HOLD_LAST;
        else if (hold != '0)
          hold_nxt = hold - HW'(1);
        if (hold == '0 && !filt[2])
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign emg_nxt = (state_nxt == ACTIVE);

  // outputs registered from next-state so ack/rise show on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      hold  <= '0;
      req   <= '0;
      sen1  <= 1'b1;
      sen2  <= 1'b1;
      ys    <= 1'b0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      req   <= req_nxt;
      sen1  <= ~(req_nxt[0] | emg_nxt);
      sen2  <= ~(req_nxt[1] | emg_nxt);
      ys    <= emg_nxt;
    end
  end

`ifdef JTD_VEH_CNT_EN
  logic [NUM_RD-1:0][CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++)
        if (rise[i] && cnt[i] != '1)
          cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

  assign veh_cnt1 = cnt[0];
  assign veh_cnt2 = cnt[1];
`else
  assign veh_cnt1 = '0;
  assign veh_cnt2 = '0;
`endif
endmodule

// File: doc/jtd_sensor_front.md
# jtd_sensor_front

Sensor front end for the crossroads traffic-light controller: produces the `sen1`, `sen2` and `ys` request inputs that the controller consumes. It synchronises and debounces two raw vehicle-loop detectors and an emergency key, and latches each road's request until the controller acknowledges it. It runs an emergency state machine with a minimum assertion time. Optional saturating per-road vehicle counters feed the display/statistics path.

## Interface
Parameters:
- `DB_CYCLES`, default 4: consecutive stable cycles required to accept a level change; minimum 2.
- `HOLD_CYCLES`, default 8: minimum number of cycles `ys` stays high once raised; minimum 1.
- `CNT_W`, default 8: width of each vehicle counter.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `det1_raw` in 1: road-1 loop detector, asynchronous, active-high.
- `det2_raw` in 1: road-2 loop detector, asynchronous, active-high.
- `emg_raw` in 1: emergency key, asynchronous, active-high.
- `ack1` in 1: controller accepts the road-1 request; single-cycle pulse, synchronous.
- `ack2` in 1: controller accepts the road-2 request; single-cycle pulse, synchronous.
- `sen1` out 1: road-1 request, active-low, registered.
- `sen2` out 1: road-2 request, active-low, registered.
- `ys` out 1: emergency request, active-high, registered.
- `veh_cnt1` out `CNT_W`: road-1 vehicle count.
- `veh_cnt2` out `CNT_W`: road-2 vehicle count.

## Operation
- **Synchronisers.** Each raw input passes through 2 flops; the flops reset to 0.
- **Debounce, per channel.**
  - Each channel keeps a filtered level `filt` and a counter `dbc`.
  - If the synchroniser output differs from `filt`, `dbc` increments.
  - When `dbc == DB_CYCLES-1` and the input still differs, `filt` toggles and `dbc` clears.
  - Any cycle where input equals `filt` clears `dbc`.
  - Result: glitches shorter than `DB_CYCLES` cycles are rejected.
- **Edge detect.** `rise_x` is `filt_x` high while its previous-cycle value was low.
- **Request latch, per road.**
  - `rise` sets the latch (`senN` goes 0).
  - `ackN` clears it.
  - If `rise` and `ack` occur in the same cycle, set wins.
  - `ack` with no pending request is ignored.
- **Emergency FSM.**
  - IDLE: `ys=0`. A rise on the filtered emergency input moves to ACTIVE and loads the hold counter with `HOLD_CYCLES-1`.
  - ACTIVE: `ys=1`; the hold counter decrements to 0. Move to IDLE when the counter is 0 and the filtered emergency input is low.
  - A new emergency rise in ACTIVE reloads the hold counter.
- **Emergency override.** While in ACTIVE, `sen1` and `sen2` are both driven 0 (all-road request encoding). The road latches keep updating underneath and reappear unchanged when the FSM returns to IDLE.
- **Vehicle counters.** On `rise_1`, `veh_cnt1` increments; same for road 2. Counters saturate at all-ones and do not wrap.

## Timing
- **Reset values.** `sen1=1`, `sen2=1`, `ys=0`, `veh_cnt1=0`, `veh_cnt2=0`. FSM in IDLE; all `filt`, `dbc`, synchroniser and hold registers at 0.
- **Reset release.** Operation resumes on the first rising edge after `rst` deasserts.
- **Reset mid-operation.** Asserting reset clears pending requests and an active emergency immediately, without waiting for a clock edge.
- **Assertion latency.** A raw input that goes high and stays stable is visible as `filt` after 2 + `DB_CYCLES` edges. `senN` or `ys` changes one edge later: 3 + `DB_CYCLES` edges total, i.e. 7 cycles at the default.
- **Deassertion latency.** The same 2 + `DB_CYCLES` edges apply to `filt` falling.
- **ACK latency.** `ackN` sampled high at edge *t* drives `senN` to 1 at edge *t* (registered output; visible after that edge).
- **Minimum `ys` width.** `ys` is high for at least `HOLD_CYCLES` cycles, even if the key is released earlier.
- **Counter timing.** Counters update on the same edge as the request latch.

## Configuration
- `JTD_VEH_CNT_EN` defined: both vehicle counters and their saturation logic are built.
- `JTD_VEH_CNT_EN` undefined: the counter registers are omitted, `veh_cnt1` and `veh_cnt2` are tied to 0, and all request and emergency behaviour is identical.

## Test plan
1. **Reset.** Hold `rst=0` with raw inputs toggling → `sen1=1`, `sen2=1`, `ys=0`, counts 0 throughout.
2. **Debounce and latch.** Pulse `det1_raw` high for 3 cycles → no response. Then hold it high → `sen1=0` exactly 7 edges after the rise. Pulse `ack1` → `sen1=1` on that edge. `veh_cnt1=1` with the counter macro defined.
3. **Set/ack collision.** `sen2` pending; `ack2` lands on the same cycle as a new debounced `det2` rise → `sen2` stays 0 and `veh_cnt2` increments.
4. **Emergency hold.** Hold `emg_raw` for 5 cycles → `ys=1` for at least 8 cycles, then 0; `sen1` and `sen2` are 0 while `ys=1`. A road-1 request latched during the emergency shows `sen1=0` after `ys` falls.
5. **Saturation.** Apply 300 debounced `det1` rises → `veh_cnt1=255`. With the counter macro undefined → `veh_cnt1=0`.
6. **Reset mid-emergency.** Drop `rst` while in ACTIVE → `ys=0` immediately, no clock edge needed. After release, a fresh emergency key is required to raise `ys` again.
